// File: rtl/pgm_ddram_rd_port_if.sv
// pgm_ddram_rd_port_if: video read client bus plus Avalon DDRAM read bus
//   vid_*   : single-word read requests from the video engine
//   DDRAM_* : burst read port toward the MiSTer DDRAM / arbiter
//   slave   : view of the line-buffer responder, master: view of the surrounding environment
interface pgm_ddram_rd_port_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
);
    logic              vid_rd;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_busy;
    logic [DATA_W-1:0] vid_dout;
    logic              vid_dout_ready;
    logic [ADDR_W-1:0] DDRAM_ADDR;
    logic [7:0]        DDRAM_BURSTCNT;
    logic              DDRAM_RD;
    logic              DDRAM_BUSY;
    logic [DATA_W-1:0] DDRAM_DOUT;
    logic              DDRAM_DOUT_READY;

    modport slave (
        input  vid_rd, vid_addr, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output vid_busy, vid_dout, vid_dout_ready, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD
    );

    modport master (
        output vid_rd, vid_addr, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  vid_busy, vid_dout, vid_dout_ready, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD
    );
endinterface

// File: rtl/pgm_ddram_rd_port.sv
// pgm_ddram_rd_port: serves single-word video reads from a one-line buffer filled by aligned DDRAM bursts
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset
//   inv     : one-cycle pulse, invalidates the line buffer
//   bus     : vid_* client side and DDRAM_* Avalon side
module pgm_ddram_rd_port #(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input logic                clk,
    input logic                reset_n,
    input logic                inv,
    pgm_ddram_rd_port_if.slave bus
);
    localparam int OFS_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] line_buf [BURST_LEN];
    logic [DATA_W-1:0] dout_q;
    logic [OFS_W-1:0]  beat_cnt;
    logic              valid, cooldown, accept, hit, beat, last_beat;

    // addr_q always carries the line tag while valid is set, so it doubles as the tag store
    assign accept    = state == IDLE && bus.vid_rd && !cooldown;
    assign hit       = valid && bus.vid_addr[ADDR_W-1:OFS_W] == addr_q[ADDR_W-1:OFS_W];
    assign beat      = state == FILL && bus.DDRAM_DOUT_READY;
    assign last_beat = beat && beat_cnt == OFS_W'(BURST_LEN - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (hit ? RESP : REQ) : IDLE;
            REQ:     state_nx = bus.DDRAM_BUSY ? REQ : FILL;
            FILL:    state_nx = last_beat ? RESP : FILL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            valid    <= 1'b0;
            cooldown <= 1'b0;
            beat_cnt <= '0;
            dout_q   <= '0;
        end else begin
            state    <= state_nx;
            cooldown <= state == RESP;
            if (accept) addr_q <= bus.vid_addr;
            if (beat) beat_cnt <= beat_cnt + 1'b1;
            if (inv || (accept && !hit)) valid <= 1'b0;
            else if (last_beat) valid <= 1'b1;
            if (state == RESP) dout_q <= line_buf[addr_q[OFS_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (beat) line_buf[beat_cnt] <= bus.DDRAM_DOUT;
    end

    // the response word is read straight from the buffer in RESP and held in dout_q afterwards
    assign bus.vid_busy       = state != IDLE || cooldown;
    assign bus.vid_dout_ready = state == RESP;
    assign bus.vid_dout       = state == RESP ? line_buf[addr_q[OFS_W-1:0]] : dout_q;
    assign bus.DDRAM_ADDR     = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign bus.DDRAM_BURSTCNT = 8'(BURST_LEN);
    assign bus.DDRAM_RD       = state == REQ;
endmodule
